// File: rtl/friscv_axi4l_initiator.sv
// AXI4-lite initiator: one single-beat read or write in flight, command/response
// handshake toward the bench, watchdog aborting any transaction that stalls.
module friscv_axi4l_initiator #(
   parameter int                  AXI_ADDR_W = 32,
   parameter int                  AXI_DATA_W = 32,
   parameter int                  AXI_ID_W   = 8,
   parameter logic [AXI_ID_W-1:0] AXI_ID     = 'h30,
   parameter int                  TIMEOUT    = 1024
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    srst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [AXI_ADDR_W-1:0]   cmd_addr,
   input  logic [AXI_DATA_W-1:0]   cmd_wdata,
   input  logic [AXI_DATA_W/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [AXI_DATA_W-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [AXI_ADDR_W-1:0]   m_awaddr,
   output logic [2:0]              m_awprot,
   output logic [AXI_ID_W-1:0]     m_awid,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic [AXI_DATA_W-1:0]   m_wdata,
   output logic [AXI_DATA_W/8-1:0] m_wstrb,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   input  logic [AXI_ID_W-1:0]     m_bid,
   input  logic [1:0]              m_bresp,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [AXI_ADDR_W-1:0]   m_araddr,
   output logic [2:0]              m_arprot,
   output logic [AXI_ID_W-1:0]     m_arid,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   input  logic [AXI_ID_W-1:0]     m_rid,
   input  logic [1:0]              m_rresp,
   input  logic [AXI_DATA_W-1:0]   m_rdata
);

   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;

   state_t                  state, state_nxt;
   logic [WDOG_W-1:0]       wdog, wdog_nxt, wdog_inc;
   logic                    aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic                    awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
   logic                    rsp_valid_nxt, rsp_timeout_nxt;
   logic [AXI_DATA_W-1:0]   rsp_rdata_nxt;
   logic [1:0]              rsp_resp_nxt;
   logic                    expired, abort;
   logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [AXI_ADDR_W-1:0]   addr_q;
   logic [AXI_DATA_W-1:0]   wdata_q;
   logic [AXI_DATA_W/8-1:0] wstrb_q;

   assign cmd_ready = (state == IDLE);
   assign aw_hs     = m_awvalid & m_awready;
   assign w_hs      = m_wvalid & m_wready;
   assign b_hs      = m_bvalid & m_bready;
   assign ar_hs     = m_arvalid & m_arready;
   assign r_hs      = m_rvalid & m_rready;

   assign m_awaddr = addr_q;
   assign m_araddr = addr_q;
   assign m_wdata  = wdata_q;
   assign m_wstrb  = wstrb_q;
   assign m_awprot = 3'b000;
   assign m_arprot = 3'b000;
   assign m_awid   = AXI_ID;
   assign m_arid   = AXI_ID;

   always_comb begin
      state_nxt       = state;
      wdog_nxt        = wdog;
      aw_done_nxt     = aw_done;
      w_done_nxt      = w_done;
      awvalid_nxt     = m_awvalid;
      wvalid_nxt      = m_wvalid;
      bready_nxt      = m_bready;
      arvalid_nxt     = m_arvalid;
      rready_nxt      = m_rready;
      rsp_valid_nxt   = rsp_valid;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_resp_nxt    = rsp_resp;
      rsp_timeout_nxt = rsp_timeout;
      abort           = 1'b0;
      wdog_inc        = wdog + WDOG_W'(1);
      expired         = (wdog_inc == WDOG_W'(TIMEOUT));

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               wdog_nxt    = '0;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               if (cmd_we) begin
                  state_nxt   = WRITE;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = READ;
                  arvalid_nxt = 1'b1;
               end
            end
         end
         WRITE: begin
            // AW and W retire independently; a handshake on the expiry cycle still counts
            wdog_nxt    = wdog_inc;
            aw_done_nxt = aw_done | aw_hs;
            w_done_nxt  = w_done | w_hs;
            if (aw_hs) awvalid_nxt = 1'b0;
            if (w_hs)  wvalid_nxt  = 1'b0;
            if ((aw_done | aw_hs) && (w_done | w_hs)) begin
               state_nxt  = WAIT_B;
               bready_nxt = 1'b1;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         WAIT_B: begin
            wdog_nxt = wdog_inc;
            if (b_hs) begin
               state_nxt       = RESP;
               bready_nxt      = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = '0;
               rsp_resp_nxt    = (m_bid == AXI_ID) ? m_bresp : 2'b11;
               rsp_timeout_nxt = 1'b0;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         READ: begin
            wdog_nxt = wdog_inc;
            if (ar_hs) begin
               state_nxt   = WAIT_R;
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         WAIT_R: begin
            wdog_nxt = wdog_inc;
            if (r_hs) begin
               state_nxt       = RESP;
               rready_nxt      = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = m_rdata;
               rsp_resp_nxt    = (m_rid == AXI_ID) ? m_rresp : 2'b11;
               rsp_timeout_nxt = 1'b0;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Watchdog abort deliberately withdraws valids mid-handshake and ignores late responses
      if (abort) begin
         state_nxt       = RESP;
         awvalid_nxt     = 1'b0;
         wvalid_nxt      = 1'b0;
         bready_nxt      = 1'b0;
         arvalid_nxt     = 1'b0;
         rready_nxt      = 1'b0;
         rsp_valid_nxt   = 1'b1;
         rsp_rdata_nxt   = '0;
         rsp_resp_nxt    = 2'b10;
         rsp_timeout_nxt = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         wdog        <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         m_awvalid   <= 1'b0;
         m_wvalid    <= 1'b0;
         m_bready    <= 1'b0;
         m_arvalid   <= 1'b0;
         m_rready    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else if (srst) begin
         state       <= IDLE;
         wdog        <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         m_awvalid   <= 1'b0;
         m_wvalid    <= 1'b0;
         m_bready    <= 1'b0;
         m_arvalid   <= 1'b0;
         m_rready    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wdog        <= wdog_nxt;
         aw_done     <= aw_done_nxt;
         w_done      <= w_done_nxt;
         m_awvalid   <= awvalid_nxt;
         m_wvalid    <= wvalid_nxt;
         m_bready    <= bready_nxt;
         m_arvalid   <= arvalid_nxt;
         m_rready    <= rready_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_resp    <= rsp_resp_nxt;
         rsp_timeout <= rsp_timeout_nxt;
      end
   end

   // Command payload needs no reset: it is only observed while a valid is up
   always_ff @(posedge aclk) begin
      if (cmd_valid && cmd_ready) begin
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
         wstrb_q <= cmd_wstrb;
      end
   end

endmodule

// File: tb/tb_friscv_axi4l_initiator.sv
// Bench for friscv_axi4l_initiator: behavioural AXI4-lite slave with configurable
// delays/responses, and a reference model predicting every response.
`timescale 1ns/1ps
module tb_friscv_axi4l_initiator;

   localparam int              AW    = 32;
   localparam int              DW    = 32;
   localparam int              IW    = 8;
   localparam int              TO    = 16;
   localparam int              STUCK = 1000;
   localparam logic [IW-1:0]   ID    = 8'h30;
   localparam logic [63:0]     RST_OUTS = 64'd1 << 41;

   logic          aclk = 1'b0;
   logic          aresetn, srst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic          m_arvalid, m_arready, m_rvalid, m_rready;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic [2:0]    m_awprot, m_arprot;
   logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_bresp, m_rresp;

   always #5 aclk = ~aclk;

   friscv_axi4l_initiator #(
      .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .AXI_ID(ID), .TIMEOUT(TO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_awprot(m_awprot), .m_awid(m_awid),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arprot(m_arprot), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rresp(m_rresp),
      .m_rdata(m_rdata)
   );

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // slave configuration, written by the main process only
   int            cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
   logic [IW-1:0] cfg_bid, cfg_rid;
   logic [1:0]    cfg_bresp, cfg_rresp;
   logic          cfg_late_r;

   // slave observations, written by the slave process only
   logic [31:0] s_mem [0:255];
   int          aw_hi, w_hi, ar_hi, b_cnt, r_cnt;

   logic [31:0] r_mem [0:255];
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] v = old;
      for (int i = 0; i < 4; i++) if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
      return v;
   endfunction

   function automatic logic [63:0] outs();
      return {22'b0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
              rsp_valid, rsp_timeout, rsp_resp, rsp_rdata};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_slave(input int awd, input int wd, input int bd, input int ard,
                            input int rd, input logic [IW-1:0] bid, input logic [1:0] bresp,
                            input logic [IW-1:0] rid, input logic [1:0] rresp);
      cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
      cfg_bid = bid; cfg_bresp = bresp; cfg_rid = rid; cfg_rresp = rresp;
   endtask

   initial begin : slave
      bit aw_got, w_got, ar_got, wr_done, b_pend, r_pend;
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs, acc, rst_seen;
      int aw_n, w_n, ar_n, b_n, r_n;
      logic [AW-1:0] awa, ara;
      logic [DW-1:0] wd;
      logic [3:0]    ws;
      {aw_got, w_got, ar_got, wr_done, b_pend, r_pend} = '0;
      {aw_n, w_n, ar_n, b_n, r_n} = '0;
      awa = '0; ara = '0; wd = '0; ws = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = '0;
      m_arready = 0; m_rvalid = 0; m_rid = '0; m_rresp = '0; m_rdata = '0;
      aw_hi = 0; w_hi = 0; ar_hi = 0; b_cnt = 0; r_cnt = 0;
      for (int i = 0; i < 256; i++) s_mem[i] = '0;
      forever begin
         @(posedge aclk);
         aw_hs = m_awvalid && m_awready;
         w_hs  = m_wvalid && m_wready;
         b_hs  = m_bvalid && m_bready;
         ar_hs = m_arvalid && m_arready;
         r_hs  = m_rvalid && m_rready;
         acc   = cmd_valid && cmd_ready;
         rst_seen = !aresetn || srst;
         if (aw_hs) awa = m_awaddr;
         if (w_hs) begin wd = m_wdata; ws = m_wstrb; end
         if (ar_hs) ara = m_araddr;
         @(negedge aclk);
         if (acc || rst_seen) begin
            {aw_got, w_got, ar_got, wr_done, b_pend, r_pend} = '0;
            {aw_n, w_n, ar_n, b_n, r_n} = '0;
            aw_hi = 0; w_hi = 0; ar_hi = 0; b_cnt = 0; r_cnt = 0;
         end
         if (aw_hs) aw_got = 1;
         if (w_hs)  w_got = 1;
         if (aw_got && w_got && !wr_done) begin
            s_mem[awa[9:2]] = merge(s_mem[awa[9:2]], wd, ws);
            wr_done = 1; b_pend = 1; b_n = 0;
         end
         if (b_hs) begin b_cnt++; b_pend = 0; end
         if (ar_hs) begin ar_got = 1; r_pend = 1; r_n = 0; end
         if (r_hs) begin r_cnt++; r_pend = 0; end
         if (m_awvalid) aw_hi++;
         if (m_wvalid)  w_hi++;
         if (m_arvalid) ar_hi++;
         m_awready = 0;
         if (m_awvalid && !aw_got) begin if (aw_n >= cfg_aw_dly) m_awready = 1; else aw_n++; end
         m_wready = 0;
         if (m_wvalid && !w_got) begin if (w_n >= cfg_w_dly) m_wready = 1; else w_n++; end
         m_arready = 0;
         if (m_arvalid && !ar_got) begin if (ar_n >= cfg_ar_dly) m_arready = 1; else ar_n++; end
         m_bvalid = 0;
         if (b_pend) begin if (b_n >= cfg_b_dly) m_bvalid = 1; else b_n++; end
         m_bid = cfg_bid; m_bresp = cfg_bresp;
         m_rvalid = cfg_late_r;
         if (r_pend) begin if (r_n >= cfg_r_dly) m_rvalid = 1; else r_n++; end
         m_rid = cfg_rid; m_rresp = cfg_rresp; m_rdata = s_mem[ara[9:2]];
      end
   end

   task automatic start_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, output int acc, output bit ok);
      int n = 0;
      cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      while (!cmd_ready && n < 50) begin @(negedge aclk); n++; end
      ok = cmd_ready;
      @(negedge aclk);
      cmd_valid = 0;
      acc = cyc;
      if (!ok) chk("cmd_accept", 0, 1);
   endtask

   task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold, input bit late,
                          input int exp_lat);
      bit          to, ok;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
      int          acc, n;
      to = we ? (cfg_aw_dly >= STUCK || cfg_w_dly >= STUCK || cfg_b_dly >= STUCK)
              : (cfg_ar_dly >= STUCK || cfg_r_dly >= STUCK);
      if (to)      e_resp = 2'b10;
      else if (we) e_resp = (cfg_bid != ID) ? 2'b11 : cfg_bresp;
      else         e_resp = (cfg_rid != ID) ? 2'b11 : cfg_rresp;
      e_rdata = (we || to) ? 32'h0 : r_mem[addr[9:2]];
      if (we && !to) r_mem[addr[9:2]] = merge(r_mem[addr[9:2]], wd, ws);

      start_cmd(we, addr, wd, ws, acc, ok);
      if (!ok) return;
      n = 0;
      while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
      if (!rsp_valid) begin chk("rsp_wait", 0, 1); return; end
      if (exp_lat >= 0) chk("latency", cyc - acc, exp_lat);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_resp", rsp_resp, e_resp);
      chk("rsp_timeout", rsp_timeout, to);
      cfg_late_r = late;
      ok = 1;
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         ok = ok && rsp_valid && (rsp_rdata == e_rdata) && (rsp_resp == e_resp) &&
              (rsp_timeout == to) && !cmd_ready &&
              !(m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready);
      end
      if (hold > 0) chk("rsp_hold", ok, 1);
      rsp_ready = 1;
      @(negedge aclk);
      rsp_ready = 0;
      cfg_late_r = 0;
      chk("rsp_release", {rsp_valid, cmd_ready}, 2'b01);
      if (we && !to) begin
         chk("aw_valid_cycles", aw_hi, cfg_aw_dly + 1);
         chk("w_valid_cycles", w_hi, cfg_w_dly + 1);
         chk("b_accepted", b_cnt, 1);
      end
      if (!we && !to) begin
         chk("ar_valid_cycles", ar_hi, cfg_ar_dly + 1);
         chk("r_accepted", r_cnt, 1);
      end
      if (!we && to) begin
         chk("wdog_ar_cycles", ar_hi, TO);
         chk("late_r_ignored", r_cnt, 0);
      end
      if (we && to && cfg_w_dly >= STUCK) chk("wdog_w_cycles", w_hi, TO);
   endtask

   task automatic reset_mid(input bit use_srst, input string tag);
      int          acc, n;
      bit          ok;
      logic [31:0] a = 32'h0000_0200;
      logic [31:0] d = $urandom;
      cfg_b_dly = STUCK;
      start_cmd(1, a, d, 4'hF, acc, ok);
      n = 0;
      while (!m_bready && n < 50) begin @(negedge aclk); n++; end
      chk({tag, "_in_wait_b"}, m_bready, 1);
      r_mem[a[9:2]] = d;
      if (use_srst) begin
         srst = 1;
         @(negedge aclk);
         chk({tag, "_outs"}, outs(), RST_OUTS);
         srst = 0;
      end else begin
         #2 aresetn = 0;
         #1 chk({tag, "_outs"}, outs(), RST_OUTS);
         @(negedge aclk);
         aresetn = 1;
      end
      ok = 1;
      repeat (4) begin @(negedge aclk); ok = ok && (outs() == RST_OUTS); end
      chk({tag, "_after"}, ok, 1);
      cfg_b_dly = 1;
   endtask

   initial begin : main
      int        awd, wdl, bd, ard, rd;
      bit        we;
      logic [IW-1:0] bid, rid;
      aresetn = 0; srst = 0; rsp_ready = 0;
      cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      cfg_late_r = 0;
      set_slave(0, 0, 1, 0, 1, ID, 2'b00, ID, 2'b00);
      for (int i = 0; i < 256; i++) r_mem[i] = '0;
      repeat (3) @(negedge aclk);
      chk("reset_outs", outs(), RST_OUTS);
      aresetn = 1;
      @(negedge aclk);
      chk("idle_outs", outs(), RST_OUTS);
      chk("fixed_fields", {m_awprot, m_arprot, m_awid, m_arid}, {6'b0, ID, ID});

      run_cmd(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 3);
      run_cmd(0, 32'h100, 32'h0, 4'h0, 0, 0, 3);

      set_slave(5, 0, 1, 0, 1, ID, 2'b00, ID, 2'b00);
      run_cmd(1, 32'h104, 32'h1234_5678, 4'h5, 0, 0, -1);

      set_slave(0, 0, 1, 0, 1, ID, 2'b00, ID, 2'b10);
      run_cmd(0, 32'h104, 32'h0, 4'h0, 0, 0, 3);
      set_slave(0, 0, 1, 0, 1, 8'h31, 2'b00, ID, 2'b00);
      run_cmd(1, 32'h108, 32'hA5A5_5A5A, 4'hF, 0, 0, 3);

      set_slave(0, 0, 1, STUCK, 1, ID, 2'b00, ID, 2'b00);
      run_cmd(0, 32'h10C, 32'h0, 4'h0, 6, 1, TO);
      set_slave(0, STUCK, 1, 0, 1, ID, 2'b00, ID, 2'b00);
      run_cmd(1, 32'h110, 32'hFFFF_FFFF, 4'hF, 0, 0, TO);

      set_slave(0, 0, 1, 0, 1, ID, 2'b00, ID, 2'b00);
      run_cmd(0, 32'h100, 32'h0, 4'h0, 10, 0, 3);

      reset_mid(0, "arst_mid_write");
      reset_mid(1, "srst_mid_write");

      for (int k = 0; k < 40; k++) begin
         we  = 1'($urandom_range(0, 1));
         awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bd = $urandom_range(0, 3);
         ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
         bid = ($urandom_range(0, 7) == 0) ? (ID ^ 8'h01) : ID;
         rid = ($urandom_range(0, 7) == 0) ? (ID ^ 8'h02) : ID;
         set_slave(awd, wdl, bd, ard, rd, bid, 2'($urandom_range(0, 3)), rid,
                   2'($urandom_range(0, 3)));
         run_cmd(we, {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
